// File: rtl/math_subtractor_brent_kung_pipe_032.sv
// Three-stage pipelined 32-bit subtractor (A - B - borrow) using a Brent-Kung carry prefix.
// Optional flags: define MATH_SUB_PIPE_FLAGS_EN for o_overflow / o_zero; otherwise they are tied to 0.
module math_subtractor_brent_kung_pipe_032 #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] o_diff,
  output logic         o_borrow,
  output logic         o_overflow,
  output logic         o_zero
);

  if (N != 32) begin : g_bad_width
    $error("math_subtractor_brent_kung_pipe_032 supports only N = 32");
  end

  logic         w_adv;
  logic         w_cin;
  logic [N-1:0] w_p0;
  logic [N-1:0] w_g0;

  logic         r1_valid, r2_valid, r3_valid;
  logic [N-1:0] r1_p, r1_g;
  logic         r1_cin, r2_cin;
  logic [N-1:0] r2_g, r2_p, r2_pbit;
  logic [N-1:0] r3_diff;
  logic         r3_borrow;

  logic [N-1:0] w_carry;
  logic [N-1:0] w_diff;
  logic         w_borrow;
  logic         w_unused_p;

  // The whole pipe freezes only when a finished result is waiting on downstream.
  assign w_adv   = ~(r3_valid & ~i_ready);
  assign o_ready = w_adv;

  assign w_cin = ~i_borrow;
  assign w_p0  = i_a ^ ~i_b;
  assign w_g0  = {i_a[N-1:1] & ~i_b[N-1:1], (i_a[0] & ~i_b[0]) | (w_p0[0] & w_cin)};

  genvar gl, gi;

  // Up-sweep levels 1..3 (spans 2, 4, 8) live in stage 2.
  for (gl = 0; gl <= 3; gl++) begin : g_s2
    logic [N-1:0] w_g, w_p;
    if (gl == 0) begin : g_root
      assign w_g = r1_g;
      assign w_p = r1_p;
    end else begin : g_lvl
      for (gi = 0; gi < N; gi++) begin : g_bit
        if (((gi + 1) % (1 << gl)) == 0) begin : g_cell
          assign w_g[gi] = g_s2[gl-1].w_g[gi] | (g_s2[gl-1].w_p[gi] & g_s2[gl-1].w_g[gi-(1<<(gl-1))]);
          assign w_p[gi] = g_s2[gl-1].w_p[gi] & g_s2[gl-1].w_p[gi-(1<<(gl-1))];
        end else begin : g_pass
          assign w_g[gi] = g_s2[gl-1].w_g[gi];
          assign w_p[gi] = g_s2[gl-1].w_p[gi];
        end
      end
    end
  end

  // Remaining up-sweep levels 4..5 (spans 16, 32) in stage 3.
  for (gl = 3; gl <= 5; gl++) begin : g_s3u
    logic [N-1:0] w_g, w_p;
    if (gl == 3) begin : g_root
      assign w_g = r2_g;
      assign w_p = r2_p;
    end else begin : g_lvl
      for (gi = 0; gi < N; gi++) begin : g_bit
        if (((gi + 1) % (1 << gl)) == 0) begin : g_cell
          assign w_g[gi] = g_s3u[gl-1].w_g[gi] | (g_s3u[gl-1].w_p[gi] & g_s3u[gl-1].w_g[gi-(1<<(gl-1))]);
          assign w_p[gi] = g_s3u[gl-1].w_p[gi] & g_s3u[gl-1].w_p[gi-(1<<(gl-1))];
        end else begin : g_pass
          assign w_g[gi] = g_s3u[gl-1].w_g[gi];
          assign w_p[gi] = g_s3u[gl-1].w_p[gi];
        end
      end
    end
  end

  // Down-sweep gray cells fill the prefixes between the up-sweep nodes.
  for (gl = 4; gl >= 0; gl--) begin : g_s3d
    logic [N-1:0] w_g;
    if (gl == 4) begin : g_root
      assign w_g = g_s3u[5].w_g;
    end else begin : g_lvl
      for (gi = 0; gi < N; gi++) begin : g_bit
        if ((((gi + 1) % (1 << (gl + 1))) == (1 << gl)) && (gi >= (1 << (gl + 1)))) begin : g_cell
          assign w_g[gi] = g_s3d[gl+1].w_g[gi] | (g_s3u[5].w_p[gi] & g_s3d[gl+1].w_g[gi-(1<<gl)]);
        end else begin : g_pass
          assign w_g[gi] = g_s3d[gl+1].w_g[gi];
        end
      end
    end
  end

  assign w_unused_p = ^g_s3u[5].w_p;
  assign w_carry    = g_s3d[0].w_g;
  assign w_diff     = r2_pbit ^ {w_carry[N-2:0], r2_cin};
  assign w_borrow   = ~w_carry[N-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_valid  <= 1'b0;
      r1_p      <= '0;
      r1_g      <= '0;
      r1_cin    <= 1'b0;
      r2_valid  <= 1'b0;
      r2_g      <= '0;
      r2_p      <= '0;
      r2_pbit   <= '0;
      r2_cin    <= 1'b0;
      r3_valid  <= 1'b0;
      r3_diff   <= '0;
      r3_borrow <= 1'b0;
    end else if (w_adv) begin
      r1_valid  <= i_valid;
      r1_p      <= w_p0;
      r1_g      <= w_g0;
      r1_cin    <= w_cin;
      r2_valid  <= r1_valid;
      r2_g      <= g_s2[3].w_g;
      r2_p      <= g_s2[3].w_p;
      r2_pbit   <= r1_p;
      r2_cin    <= r1_cin;
      r3_valid  <= r2_valid;
      r3_diff   <= w_diff;
      r3_borrow <= w_borrow;
    end
  end

`ifdef MATH_SUB_PIPE_FLAGS_EN
  logic r1_a31, r1_b31, r2_a31, r2_b31;
  logic r3_overflow, r3_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_a31      <= 1'b0;
      r1_b31      <= 1'b0;
      r2_a31      <= 1'b0;
      r2_b31      <= 1'b0;
      r3_overflow <= 1'b0;
      r3_zero     <= 1'b0;
    end else if (w_adv) begin
      r1_a31      <= i_a[N-1];
      r1_b31      <= i_b[N-1];
      r2_a31      <= r1_a31;
      r2_b31      <= r1_b31;
      r3_overflow <= (r2_a31 ^ r2_b31) & (w_diff[N-1] ^ r2_a31);
      r3_zero     <= ~|w_diff;
    end
  end

  assign o_overflow = r3_overflow;
  assign o_zero     = r3_zero;
`else
  assign o_overflow = 1'b0;
  assign o_zero     = 1'b0;
`endif

  assign o_valid  = r3_valid;
  assign o_diff   = r3_diff;
  assign o_borrow = r3_borrow;

endmodule

// File: tb/tb_math_subtractor_brent_kung_pipe_032.sv
// Directed bench for the pipelined Brent-Kung subtractor: vectors, backpressure, reset mid-stream.
module tb_math_subtractor_brent_kung_pipe_032;

`ifdef MATH_SUB_PIPE_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_borrow = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_diff;
  logic        o_borrow;
  logic        o_overflow;
  logic        o_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  math_subtractor_brent_kung_pipe_032 #(.N(32)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_a(i_a), .i_b(i_b), .i_borrow(i_borrow), .o_valid(o_valid), .i_ready(i_ready),
    .o_diff(o_diff), .o_borrow(o_borrow), .o_overflow(o_overflow), .o_zero(o_zero)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result packed as {zero, overflow, borrow, diff}.
  function automatic logic [34:0] ref_sub(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0] t;
    logic        ovf;
    t   = {1'b0, a} - {1'b0, b} - {32'b0, bin};
    ovf = (a[31] ^ b[31]) & (t[31] ^ a[31]);
    return {FLAGS & (t[31:0] == 32'd0), FLAGS & ovf, t[32], t[31:0]};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b, input logic bin,
                         input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
    @(negedge clk);
    i_a = a; i_b = b; i_borrow = bin; i_valid = 1'b1; i_ready = 1'b1;
    #1 check_eq({tag, ".ready"}, o_ready, 1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    check_eq({tag, ".lat1"}, o_valid, 0);
    @(posedge clk);
    #1 check_eq({tag, ".lat2"}, o_valid, 0);
    @(posedge clk);
    #1 check_eq({tag, ".valid"}, o_valid, 1);
    check_eq({tag, ".diff"}, o_diff, ed);
    check_eq({tag, ".borrow"}, o_borrow, eb);
    check_eq({tag, ".ovf"}, o_overflow, FLAGS & eo);
    check_eq({tag, ".zero"}, o_zero, FLAGS & ez);
    $display("op %s: %08h - %08h - %0d -> diff=%08h borrow=%0d ovf=%0d zero=%0d",
             tag, a, b, bin, o_diff, o_borrow, o_overflow, o_zero);
  endtask

  logic [31:0] s_a [10];
  logic [31:0] s_b [10];
  logic        s_c [10];
  logic [34:0] expq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent, rcvd;
    logic [34:0] held, exp_r;
    logic        prev_stall;

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_eq("rst.valid", o_valid, 0);
    check_eq("rst.diff", o_diff, 0);
    check_eq("rst.borrow", o_borrow, 0);
    check_eq("rst.ready", o_ready, 1);
    @(negedge clk) i_rst_n = 1'b1;

    // Directed vectors with hand-computed results
    run_one("5-3",        32'd5,         32'd3,         1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    run_one("0-1",        32'd0,         32'd1,         1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_one("0-0-1",      32'd0,         32'd0,         1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    run_one("min-1",      32'h80000000,  32'd1,         1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    run_one("max-neg1",   32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
    run_one("7-7",        32'd7,         32'd7,         1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_one("7-6-1",      32'd7,         32'd6,         1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    run_one("ffff-0",     32'hFFFFFFFF,  32'd0,         1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_one("carrychain", 32'h00010000,  32'h00000001,  1'b1, 32'h0000FFFE, 1'b0, 1'b0, 1'b0);

    // Drain the last directed result before streaming
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    @(posedge clk);

    // Streaming with a 4-cycle downstream stall
    for (int k = 0; k < 10; k++) begin
      s_a[k] = $urandom; s_b[k] = $urandom; s_c[k] = 1'($urandom_range(1));
    end
    sent = 0; rcvd = 0; prev_stall = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 10; cyc++) begin
      @(negedge clk);
      i_ready = !(cyc >= 6 && cyc < 10);
      i_valid = (sent < 10);
      if (sent < 10) begin
        i_a = s_a[sent]; i_b = s_b[sent]; i_borrow = s_c[sent];
      end
      #1;
      if (cyc >= 6 && cyc < 10) begin
        check_eq("stream.stall_ready", o_ready, 0);
        check_eq("stream.stall_valid", o_valid, 1);
      end else begin
        check_eq("stream.ready", o_ready, 1);
      end
      if (o_valid && !i_ready) begin
        if (prev_stall) check_eq("stream.hold", {o_zero, o_overflow, o_borrow, o_diff}, held);
        held = {o_zero, o_overflow, o_borrow, o_diff};
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          check_eq("stream.extra", 1, 0);
        end else begin
          exp_r = expq.pop_front();
          check_eq("stream.result", {o_zero, o_overflow, o_borrow, o_diff}, exp_r);
          $display("stream result %0d: diff=%08h borrow=%0d", rcvd, o_diff, o_borrow);
        end
        rcvd++;
      end
      if (i_valid && o_ready) begin
        expq.push_back(ref_sub(i_a, i_b, i_borrow));
        sent++;
      end
    end
    check_eq("stream.count", rcvd, 10);
    check_eq("stream.left", expq.size(), 0);

    // Fill the pipe with three ops while downstream is stalled, then reset
    @(negedge clk);
    i_ready = 1'b0; i_valid = 1'b1; i_a = 32'd0; i_b = 32'd1; i_borrow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    #1 check_eq("fill.valid", o_valid, 1);
    check_eq("fill.ready", o_ready, 0);
    check_eq("fill.diff", o_diff, 32'hFFFFFFFF);
    i_rst_n = 1'b0;
    #1 check_eq("midrst.valid", o_valid, 0);
    check_eq("midrst.diff", o_diff, 0);
    check_eq("midrst.borrow", o_borrow, 0);
    check_eq("midrst.ovf", o_overflow, 0);
    check_eq("midrst.zero", o_zero, 0);
    repeat (2) @(posedge clk);
    #1 check_eq("midrst.held_valid", o_valid, 0);
    @(negedge clk);
    i_rst_n = 1'b1; i_ready = 1'b1;
    #1 check_eq("postrst.ready", o_ready, 1);
    run_one("postrst", 32'd100, 32'd58, 1'b1, 32'd41, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
